// File: rtl/run_ctrl_if.sv
// Control/status and core-side bundle for run_ctrl.
// slave: run_ctrl's view (takes start/config/core fetch info, drives reset/debug/status).
// master: the host/core side that drives start, config, pc, stall_F and dbg_data.
interface run_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             start;
  logic [XLEN-1:0]  halt_addr;
  logic [XLEN-1:0]  expect_sig;
  logic [XLEN-1:0]  pc;
  logic             stall_F;
  logic [XLEN-1:0]  dbg_data;
  logic             core_reset;
  logic             dbg_en;
  logic [AW-1:0]    dbg_addr;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [XLEN-1:0]  signature;
  logic [CNT_W-1:0] instret_count;
  logic [CNT_W-1:0] stall_count;

  modport slave (
    input  start, halt_addr, expect_sig, pc, stall_F, dbg_data,
    output core_reset, dbg_en, dbg_addr, busy, done, pass, timeout,
           cycle_count, signature, instret_count, stall_count
  );

  modport master (
    output start, halt_addr, expect_sig, pc, stall_F, dbg_data,
    input  core_reset, dbg_en, dbg_addr, busy, done, pass, timeout,
           cycle_count, signature, instret_count, stall_count
  );
endinterface

// File: rtl/run_ctrl.sv
// Run/check controller: holds core reset, runs until halt_addr is fetched HALT_HITS
// times, drains, reads x1..x(NREGS-1) over the debug port and folds them into a signature.
// Ports: clk, reset (async active-low), bus (run_ctrl_if.slave: start/config, pc/stall_F,
// dbg_data in; core_reset, dbg_en/dbg_addr, busy/done/pass/timeout, counters, signature out).
// Optional perf counters (instret_count/stall_count) are built when RUN_CTRL_PERF_EN is defined.
module run_ctrl #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int CNT_W        = 32,
  parameter int RST_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 5,
  parameter int HALT_HITS    = 2,
  parameter int MAX_CYCLES   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  run_ctrl_if.slave   bus
);
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int PH_W = 16;
  localparam int HW   = $clog2(HALT_HITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_DRAIN, S_CHECK, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [HW-1:0]    hits_q, hits_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [XLEN-1:0]  sig_q, sig_d;
  logic             rd_vld_q, rd_vld_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic             hit, last_hit, run_expire, start_run;
  logic             core_reset, busy, dbg_en;
  logic [AW-1:0]    dbg_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Halt detection: only unstalled fetches of halt_addr count.
  assign hit        = !bus.stall_F && (bus.pc == bus.halt_addr);
  assign last_hit   = hit && (hits_q == HW'(HALT_HITS - 1));
  assign run_expire = (sat_inc(cycle_q) == CNT_W'(MAX_CYCLES));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_HOLD;
      S_HOLD:  if (phase_q == PH_W'(RST_CYCLES - 1)) state_d = S_RUN;
      S_RUN: begin
        // Halt takes priority over a budget that expires in the same cycle.
        if (last_hit)        state_d = S_DRAIN;
        else if (run_expire) state_d = S_DONE;
      end
      S_DRAIN: if (phase_q == PH_W'(DRAIN_CYCLES - 1)) state_d = S_CHECK;
      S_CHECK: if (phase_q == PH_W'(NREGS - 1)) state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    core_reset = 1'b0;
    busy       = 1'b0;
    dbg_en     = 1'b0;
    dbg_addr   = '0;
    unique case (state_q)
      S_IDLE:  core_reset = 1'b1;
      S_HOLD:  begin core_reset = 1'b1; busy = 1'b1; end
      S_RUN:   busy = 1'b1;
      S_DRAIN: busy = 1'b1;
      S_CHECK: begin
        busy = 1'b1;
        // Reads issue on phases 0..NREGS-2; the final phase only collects the last data.
        if (phase_q < PH_W'(NREGS - 1)) begin
          dbg_en   = 1'b1;
          dbg_addr = AW'(phase_q + PH_W'(1));
        end
      end
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  assign start_run = (state_d == S_HOLD) && (state_q != S_HOLD);

  always_comb begin
    phase_d   = '0;
    hits_d    = hits_q;
    cycle_d   = cycle_q;
    sig_d     = sig_q;
    rd_vld_d  = dbg_en;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;

    if ((state_d == state_q) &&
        (state_q == S_HOLD || state_q == S_DRAIN || state_q == S_CHECK))
      phase_d = phase_q + PH_W'(1);

    if (start_run) begin
      hits_d    = '0;
      cycle_d   = '0;
      sig_d     = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else begin
      if (state_q == S_RUN || state_q == S_DRAIN) cycle_d = sat_inc(cycle_q);
      if (state_q == S_RUN && hit && !last_hit)   hits_d  = hits_q + HW'(1);
      // Debug data lags its address by one cycle.
      if (rd_vld_q) sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ bus.dbg_data;
      if (state_q == S_RUN && state_d == S_DONE) begin
        done_d    = 1'b1;
        timeout_d = 1'b1;
        pass_d    = 1'b0;
      end
      if (state_q == S_CHECK && state_d == S_DONE) begin
        done_d    = 1'b1;
        timeout_d = 1'b0;
        pass_d    = (sig_d == bus.expect_sig);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= '0;
      hits_q    <= '0;
      cycle_q   <= '0;
      sig_q     <= '0;
      rd_vld_q  <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      hits_q    <= hits_d;
      cycle_q   <= cycle_d;
      sig_q     <= sig_d;
      rd_vld_q  <= rd_vld_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef RUN_CTRL_PERF_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    instret_d   = instret_q;
    stall_cnt_d = stall_cnt_q;
    if (start_run) begin
      instret_d   = '0;
      stall_cnt_d = '0;
    end else if (state_q == S_RUN) begin
      if (bus.stall_F) stall_cnt_d = sat_inc(stall_cnt_q);
      else             instret_d   = sat_inc(instret_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      instret_q   <= instret_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.instret_count = instret_q;
  assign bus.stall_count   = stall_cnt_q;
`else
  assign bus.instret_count = '0;
  assign bus.stall_count   = '0;
`endif

  assign bus.core_reset  = core_reset;
  assign bus.busy        = busy;
  assign bus.dbg_en      = dbg_en;
  assign bus.dbg_addr    = dbg_addr;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_q;
  assign bus.signature   = sig_q;
endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  run_ctrl_if #(.XLEN(32), .NREGS(32), .CNT_W(32)) bus ();

  run_ctrl #(
    .XLEN(32), .NREGS(32), .CNT_W(32), .RST_CYCLES(4),
    .DRAIN_CYCLES(5), .HALT_HITS(2), .MAX_CYCLES(1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Register file model: x_i = i, read data one cycle after the address.
  logic [31:0] regs [32];
  initial for (int i = 0; i < 32; i++) regs[i] = 32'(i);
  always @(posedge clk) if (bus.dbg_en) bus.dbg_data <= regs[bus.dbg_addr];

  function automatic logic [31:0] fold_regs();
    logic [31:0] s;
    s = 32'h0;
    for (int i = 1; i < 32; i++) s = {s[30:0], s[31]} ^ regs[i];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Pulse start and step through HOLD; returns with the first RUN cycle's inputs to drive.
  task automatic begin_run();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
  endtask

  // Standard halt run: 3 non-halt fetches, then two unstalled fetches of 0x40.
  task automatic run_halt(input logic [31:0] exp, output int n_rd, output bit addr_ok,
                          output bit ok);
    bus.expect_sig = exp;
    bus.halt_addr  = 32'h40;
    bus.stall_F    = 1'b0;
    bus.pc         = 32'h0;
    begin_run();
    bus.pc = 32'h10; repeat (3) tick();
    bus.pc = 32'h40; repeat (2) tick();
    bus.pc = 32'h44;
    n_rd = 0; addr_ok = 1'b1; ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.dbg_en) begin
        n_rd++;
        if (bus.dbg_addr !== 5'(n_rd)) addr_ok = 1'b0;
      end
      if (bus.done) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    tests_run += 6;
    if (bus.core_reset !== 1'b1) begin tests_failed++; $display("FAIL reset_core_reset got %0b want 1", bus.core_reset); end
    if (bus.busy !== 1'b0)       begin tests_failed++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    if ({bus.done, bus.pass, bus.timeout} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %03b want 000", {bus.done, bus.pass, bus.timeout}); end
    if (bus.cycle_count !== 32'd0) begin tests_failed++; $display("FAIL reset_cycle_count got %0d want 0", bus.cycle_count); end
    if (bus.signature !== 32'd0)   begin tests_failed++; $display("FAIL reset_signature got %h want 0", bus.signature); end
    if (bus.dbg_en !== 1'b0 || bus.dbg_addr !== 5'd0) begin tests_failed++; $display("FAIL reset_dbg got en=%0b addr=%0d want 0/0", bus.dbg_en, bus.dbg_addr); end
    reset = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (bus.core_reset !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_stays got core_reset=%0b busy=%0b want 1/0", bus.core_reset, bus.busy); end
  endtask

  task automatic test_hold();
    bus.pc = 32'h0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (bus.core_reset !== 1'b1 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL hold_cycle%0d got core_reset=%0b busy=%0b want 1/1", i, bus.core_reset, bus.busy); end
      tick();
    end
    tests_run++;
    if (bus.core_reset !== 1'b0 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL hold_release got core_reset=%0b busy=%0b want 0/1", bus.core_reset, bus.busy); end
    do_reset();
  endtask

  task automatic test_pass_run();
    int n; bit aok, ok;
    logic [31:0] exp;
    exp = fold_regs();
    run_halt(exp, n, aok, ok);
    tests_run += 8;
    if (!ok)       begin tests_failed++; $display("FAIL pass_done got done=%0b want 1 within budget", bus.done); end
    if (n != 31)   begin tests_failed++; $display("FAIL pass_reads got %0d want 31", n); end
    if (!aok)      begin tests_failed++; $display("FAIL pass_addr_walk got out-of-order address want 1..31"); end
    if (bus.pass !== 1'b1 || bus.timeout !== 1'b0) begin tests_failed++; $display("FAIL pass_flags got pass=%0b timeout=%0b want 1/0", bus.pass, bus.timeout); end
    if (bus.signature !== exp) begin tests_failed++; $display("FAIL pass_signature got %h want %h", bus.signature, exp); end
    if (bus.cycle_count !== 32'd10) begin tests_failed++; $display("FAIL pass_cycle_count got %0d want 10", bus.cycle_count); end
    if (bus.busy !== 1'b0 || bus.core_reset !== 1'b0 || bus.dbg_en !== 1'b0) begin tests_failed++; $display("FAIL pass_done_outs got busy=%0b core_reset=%0b dbg_en=%0b want 0/0/0", bus.busy, bus.core_reset, bus.dbg_en); end
`ifdef RUN_CTRL_PERF_EN
    if (bus.instret_count !== 32'd5 || bus.stall_count !== 32'd0) begin tests_failed++; $display("FAIL pass_perf got instret=%0d stall=%0d want 5/0", bus.instret_count, bus.stall_count); end
`else
    if (bus.instret_count !== 32'd0 || bus.stall_count !== 32'd0) begin tests_failed++; $display("FAIL pass_perf_tied got instret=%0d stall=%0d want 0/0", bus.instret_count, bus.stall_count); end
`endif
  endtask

  task automatic test_back_to_back();
    repeat (3) tick();
    tests_run++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.cycle_count !== 32'd10) begin tests_failed++; $display("FAIL done_hold got done=%0b pass=%0b cycles=%0d want 1/1/10", bus.done, bus.pass, bus.cycle_count); end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tests_run += 2;
    if (bus.done !== 1'b0 || bus.pass !== 1'b0 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL restart_flags got done=%0b pass=%0b busy=%0b want 0/0/1", bus.done, bus.pass, bus.busy); end
    if (bus.cycle_count !== 32'd0 || bus.signature !== 32'd0) begin tests_failed++; $display("FAIL restart_clear got cycles=%0d sig=%h want 0/0", bus.cycle_count, bus.signature); end
    do_reset();
  endtask

  task automatic test_fail_run();
    int n; bit aok, ok;
    run_halt(32'hDEADBEEF, n, aok, ok);
    tests_run += 2;
    if (!ok || bus.pass !== 1'b0 || bus.timeout !== 1'b0) begin tests_failed++; $display("FAIL mismatch_flags got done=%0b pass=%0b timeout=%0b want 1/0/0", bus.done, bus.pass, bus.timeout); end
    if (bus.signature !== fold_regs()) begin tests_failed++; $display("FAIL mismatch_signature got %h want %h", bus.signature, fold_regs()); end
  endtask

  task automatic test_stall_hits();
    bit ok;
    bus.expect_sig = fold_regs();
    bus.halt_addr  = 32'h40;
    bus.pc = 32'h0; bus.stall_F = 1'b0;
    begin_run();
    bus.pc = 32'h40; bus.stall_F = 1'b1;
    tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;   // ignored while busy
    tick();
    bus.stall_F = 1'b0; tick();                   // first hit
    bus.stall_F = 1'b1; repeat (2) tick();
    bus.stall_F = 1'b0; tick();                   // second hit -> DRAIN
    bus.pc = 32'h44;
    tests_run++;
    if (bus.core_reset !== 1'b0 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL busy_start_ignored got core_reset=%0b busy=%0b want 0/1", bus.core_reset, bus.busy); end
    repeat (4) tick();
    tests_run++;
    if (bus.dbg_en !== 1'b0) begin tests_failed++; $display("FAIL stall_drain_early got dbg_en=%0b want 0", bus.dbg_en); end
    tick();
    tests_run++;
    if (bus.dbg_en !== 1'b1 || bus.dbg_addr !== 5'd1) begin tests_failed++; $display("FAIL stall_check_start got dbg_en=%0b addr=%0d want 1/1", bus.dbg_en, bus.dbg_addr); end
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done) begin ok = 1'b1; break; end
      tick();
    end
    tests_run += 2;
    if (!ok || bus.pass !== 1'b1) begin tests_failed++; $display("FAIL stall_pass got done=%0b pass=%0b want 1/1", bus.done, bus.pass); end
    if (bus.cycle_count !== 32'd12) begin tests_failed++; $display("FAIL stall_cycle_count got %0d want 12", bus.cycle_count); end
`ifdef RUN_CTRL_PERF_EN
    tests_run++;
    if (bus.instret_count !== 32'd2 || bus.stall_count !== 32'd5) begin tests_failed++; $display("FAIL stall_perf got instret=%0d stall=%0d want 2/5", bus.instret_count, bus.stall_count); end
`endif
  endtask

  task automatic test_timeout();
    bit ok, saw_dbg;
    bus.halt_addr = 32'h40; bus.pc = 32'h0; bus.stall_F = 1'b0;
    begin_run();
    bus.pc = 32'h10;
    ok = 1'b0; saw_dbg = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      if (bus.dbg_en) saw_dbg = 1'b1;
      if (bus.done) begin ok = 1'b1; break; end
      tick();
    end
    tests_run += 3;
    if (!ok || bus.timeout !== 1'b1 || bus.pass !== 1'b0) begin tests_failed++; $display("FAIL timeout_flags got done=%0b timeout=%0b pass=%0b want 1/1/0", bus.done, bus.timeout, bus.pass); end
    if (bus.cycle_count !== 32'd1000) begin tests_failed++; $display("FAIL timeout_cycle_count got %0d want 1000", bus.cycle_count); end
    if (saw_dbg) begin tests_failed++; $display("FAIL timeout_no_dbg got dbg_en=1 want 0"); end
`ifdef RUN_CTRL_PERF_EN
    tests_run++;
    if (bus.instret_count !== 32'd1000 || bus.stall_count !== 32'd0) begin tests_failed++; $display("FAIL timeout_perf got instret=%0d stall=%0d want 1000/0", bus.instret_count, bus.stall_count); end
`endif
  endtask

  task automatic test_halt_wins();
    bit ok;
    bus.expect_sig = fold_regs();
    bus.halt_addr = 32'h40; bus.pc = 32'h0; bus.stall_F = 1'b0;
    begin_run();
    bus.pc = 32'h40; tick();               // RUN cycle 1: first hit
    bus.pc = 32'h10; repeat (998) tick();  // cycles 2..999
    bus.pc = 32'h40; tick();               // cycle 1000: final hit and budget together
    bus.pc = 32'h44;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (bus.done) begin ok = 1'b1; break; end
      tick();
    end
    tests_run += 2;
    if (!ok || bus.timeout !== 1'b0 || bus.pass !== 1'b1) begin tests_failed++; $display("FAIL halt_wins_flags got done=%0b timeout=%0b pass=%0b want 1/0/1", bus.done, bus.timeout, bus.pass); end
    if (bus.cycle_count !== 32'd1005) begin tests_failed++; $display("FAIL halt_wins_cycle_count got %0d want 1005", bus.cycle_count); end
  endtask

  task automatic test_midrun_reset();
    bus.halt_addr = 32'h40; bus.pc = 32'h0; bus.stall_F = 1'b0;
    begin_run();
    bus.pc = 32'h10;
    repeat (3) tick();
    reset = 1'b0;
    #2;
    tests_run += 2;
    if (bus.core_reset !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL midrun_reset_outs got core_reset=%0b busy=%0b done=%0b want 1/0/0", bus.core_reset, bus.busy, bus.done); end
    if (bus.cycle_count !== 32'd0) begin tests_failed++; $display("FAIL midrun_reset_count got %0d want 0", bus.cycle_count); end
    #3;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    bus.start = 1'b0; bus.pc = 32'h0; bus.stall_F = 1'b0;
    bus.halt_addr = 32'h40; bus.expect_sig = 32'h0;
    reset = 1'b0;
    test_reset();
    test_hold();
    test_pass_run();
    test_back_to_back();
    test_fail_run();
    test_stall_hits();
    test_timeout();
    test_halt_wins();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
